fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_queue.sv | 77 +++++++
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Entry states: FREE | slot unused ; ALLOC | pc known, word outstanding ; FILLED | word present
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      ALLOC  = 2'd1,
      FILLED = 2'd2
   } entry_state_t;

   typedef struct packed {
      entry_state_t state;
      logic [31:0]  pc;
      logic [31:0]  instr;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h3;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order circular buffer of fetched instructions; entries are allocated at
// request time and filled in order as responses return.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          alloc,
   input  logic [31:0]   alloc_pc,
   input  logic          fill,
   input  logic [31:0]   fill_data,
   input  logic          pop,
   output logic [CW-1:0] count,
   output logic [CW-1:0] pend,
   output entry_state_t  head_state,
   output logic [31:0]   head_pc,
   output logic [31:0]   head_instr
);

   fetch_entry_t ent [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [PW-1:0] fptr;

   assign head_state = ent[head].state;
   assign head_pc    = ent[head].pc;
   assign head_instr = ent[head].instr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent[i] <= '{state: FREE, pc: 32'h0, instr: NOP_INSTR};
         end
         head  <= '0;
         tail  <= '0;
         fptr  <= '0;
         count <= '0;
         pend  <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent[i].state <= FREE;
         end
         head  <= '0;
         tail  <= '0;
         fptr  <= '0;
         count <= '0;
         pend  <= '0;
      end else begin
         if (alloc) begin
            ent[tail].state <= ALLOC;
            ent[tail].pc    <= alloc_pc;
            ent[tail].instr <= NOP_INSTR;
            tail            <= tail + PW'(1);
         end
         // a fill that is popped in the same cycle (bypass) never lands
         if (fill && !(pop && (fptr == head))) begin
            ent[fptr].state <= FILLED;
            ent[fptr].instr <= fill_data;
         end
         if (fill) begin
            fptr <= fptr + PW'(1);
         end
         if (pop) begin
            ent[head].state <= FREE;
            head            <= head + PW'(1);
         end
         count <= count + CW'(alloc) - CW'(pop);
         pend  <= pend + CW'(alloc) - CW'(fill);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC, request credit, redirect flush with response dropping.
// Optional FETCH_BYPASS_EN forwards a response straight to the output when it fills the head.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        taken,
   input  logic [31:0] target,
   output logic        req_valid,
   input  logic        req_ready,
   output logic [31:0] req_addr,
   input  logic        resp_valid,
   input  logic [31:0] resp_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [31:0]   pc;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] count;
   logic [CW-1:0] pend;
   entry_state_t  head_state;
   logic [31:0]   head_pc;
   logic [31:0]   head_instr;
   logic          issue;
   logic          drop;
   logic          fill;
   logic          resp_used;
   logic          bypass;
   logic          pop;

   always_comb begin
      drop      = resp_valid && (drop_cnt != '0);
      fill      = resp_valid && (drop_cnt == '0) && (pend != '0);
      resp_used = drop || fill;
      // credit covers both queued entries and responses still owed from before a redirect
      req_valid = !rst && !taken && ((32'(count) + 32'(drop_cnt)) < 32'(DEPTH));
      issue     = req_valid && req_ready;
`ifdef FETCH_BYPASS_EN
      bypass    = (head_state == ALLOC) && fill;
`else
      bypass    = 1'b0;
`endif
      out_valid = (head_state == FILLED) || bypass;
      if (head_state == FILLED) begin
         out_instr = head_instr;
      end else if (bypass) begin
         out_instr = resp_data;
      end else begin
         out_instr = NOP_INSTR;
      end
      out_pc    = out_valid ? head_pc : 32'h0;
      pop       = out_valid && out_ready && !taken;
   end

   assign req_addr = pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc       <= RESET_PC;
         drop_cnt <= '0;
      end else if (taken) begin
         pc       <= word_align(target);
         drop_cnt <= drop_cnt + pend - CW'(resp_used);
      end else begin
         if (issue) begin
            pc <= pc + 32'd4;
         end
         if (drop) begin
            drop_cnt <= drop_cnt - CW'(1);
         end
      end
   end

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk        (clk),
      .rst        (rst),
      .flush      (taken),
      .alloc      (issue),
      .alloc_pc   (pc),
      .fill       (fill),
      .fill_data  (resp_data),
      .pop        (pop),
      .count      (count),
      .pend       (pend),
      .head_state (head_state),
      .head_pc    (head_pc),
      .head_instr (head_instr)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order, fixed-latency memory model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        taken;
   logic [31:0] target;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int lat      = 1;
   int base     = 0;
   int npre     = 0;

   logic [31:0] mem_addr_q[$];
   int          mem_due_q[$];
   logic [31:0] acc_q[$];
   logic [31:0] pop_pc_q[$];
   logic [31:0] pop_instr_q[$];
   int          pop_cyc_q[$];

   fetch_unit #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .rst        (rst),
      .taken      (taken),
      .target     (target),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_pc     (out_pc),
      .out_instr  (out_instr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a ^ 32'h1234_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      mem_addr_q.delete();
      mem_due_q.delete();
      acc_q.delete();
      pop_pc_q.delete();
      pop_instr_q.delete();
      pop_cyc_q.delete();
   endtask

   // memory: answers each accepted request lat cycles later, in order
   initial begin
      resp_valid = 1'b0;
      resp_data  = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
            resp_valid = 1'b1;
            resp_data  = word_of(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
         end else begin
            resp_valid = 1'b0;
         end
      end
   end

   // observes handshakes mid-cycle, when inputs and outputs are settled
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            mem_addr_q.delete();
            mem_due_q.delete();
         end else begin
            if (req_valid && req_ready) begin
               acc_q.push_back(req_addr);
               mem_addr_q.push_back(req_addr);
               mem_due_q.push_back(cyc + lat);
            end
            if (out_valid && out_ready && !taken) begin
               pop_pc_q.push_back(out_pc);
               pop_instr_q.push_back(out_instr);
               pop_cyc_q.push_back(cyc);
            end
         end
      end
   end

   task automatic do_reset();
      tick();
      rst = 1'b1;
      @(negedge clk);
      tick();
      clear_logs();
      rst  = 1'b0;
      base = cyc;
   endtask

   initial begin
      int exp_first;
      rst       = 1'b1;
      taken     = 1'b0;
      target    = 32'h0;
      req_ready = 1'b1;
      out_ready = 1'b1;

      // reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_valid", {31'h0, req_valid}, 32'h0);
      chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_out_pc", out_pc, 32'h0);
      chk("rst_out_instr", out_instr, 32'h0000_0013);

      // streaming
      tick();
      clear_logs();
      rst  = 1'b0;
      base = cyc;
      @(negedge clk);
      chk("first_req_valid", {31'h0, req_valid}, 32'h1);
      chk("first_req_addr", req_addr, 32'h0);
      repeat (12) tick();
      chk("stream_acc0", acc_q[0], 32'h0);
      chk("stream_acc1", acc_q[1], 32'h4);
      chk("stream_acc2", acc_q[2], 32'h8);
      chk("stream_acc3", acc_q[3], 32'hC);
      chk("stream_pop0", pop_pc_q[0], 32'h0);
      chk("stream_pop1", pop_pc_q[1], 32'h4);
      chk("stream_pop2", pop_pc_q[2], 32'h8);
      chk("stream_pop3", pop_pc_q[3], 32'hC);
      chk("stream_instr0", pop_instr_q[0], 32'h1234_0000);
      chk("stream_instr3", pop_instr_q[3], 32'h1234_000C);
`ifdef FETCH_BYPASS_EN
      exp_first = 1;
`else
      exp_first = 2;
`endif
      chk("resp_to_out_latency", pop_cyc_q[0] - base, exp_first);

      // stall with out_ready low: queue fills, then no more requests
      out_ready = 1'b0;
      do_reset();
      repeat (10) tick();
      @(negedge clk);
      chk("stall_req_count", acc_q.size(), 2);
      chk("stall_req_valid", {31'h0, req_valid}, 32'h0);
      chk("stall_out_valid", {31'h0, out_valid}, 32'h1);
      chk("stall_out_pc", out_pc, 32'h0);
      tick();
      out_ready = 1'b1;
      repeat (8) tick();
      chk("stall_pop0", pop_pc_q[0], 32'h0);
      chk("stall_pop1", pop_pc_q[1], 32'h4);
      chk("stall_pop2", pop_pc_q[2], 32'h8);
      chk("stall_resume_acc", acc_q[2], 32'h8);

      // fill again, then reset with the queue full
      out_ready = 1'b0;
      repeat (6) tick();
      @(negedge clk);
      chk("full_out_valid", {31'h0, out_valid}, 32'h1);
      chk("full_req_valid", {31'h0, req_valid}, 32'h0);
      tick();
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("midrst_out_pc", out_pc, 32'h0);
      chk("midrst_out_instr", out_instr, 32'h0000_0013);
      chk("midrst_req_valid", {31'h0, req_valid}, 32'h0);

      // redirect with two requests in flight
      out_ready = 1'b1;
      lat = 4;
      @(negedge clk);
      tick();
      clear_logs();
      rst  = 1'b0;
      base = cyc;
      @(negedge clk);
      chk("postrst_req_addr", req_addr, 32'h0);
      chk("postrst_req_valid", {31'h0, req_valid}, 32'h1);
      tick();
      tick();
      taken  = 1'b1;
      target = 32'h0000_0100;
      @(negedge clk);
      chk("redir_req_valid", {31'h0, req_valid}, 32'h0);
      chk("redir_inflight", acc_q.size(), 2);
      tick();
      taken = 1'b0;
      @(negedge clk);
      chk("redir_next_addr", req_addr, 32'h0000_0100);
      repeat (12) tick();
      chk("redir_acc", acc_q[2], 32'h0000_0100);
      chk("redir_pop_pc", pop_pc_q[0], 32'h0000_0100);
      chk("redir_pop_instr", pop_instr_q[0], 32'h1234_0100);

      // redirect coincident with a response and a pop-ready head
      lat = 1;
      do_reset();
      tick();
      tick();
      taken  = 1'b1;
      target = 32'h0000_0203;
      @(negedge clk);
      chk("coin_req_valid", {31'h0, req_valid}, 32'h0);
      tick();
      taken = 1'b0;
      @(negedge clk);
      chk("coin_next_addr", req_addr, 32'h0000_0200);
      chk("coin_next_valid", {31'h0, req_valid}, 32'h1);
      chk("coin_flushed", {31'h0, out_valid}, 32'h0);
      npre = pop_pc_q.size();
      repeat (6) tick();
      chk("coin_pop_pc", pop_pc_q[npre], 32'h0000_0200);
      chk("coin_pop_instr", pop_instr_q[npre], 32'h1234_0200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
